// File: rtl/decode_stage.sv
// decode_stage: registered RV32IM instruction decode with a DEPTH-entry
// output FIFO and valid/ready handshakes on both sides.
// Optional feature: define RV32M_DECODE_EN to decode the M extension
// (funct7=0000001 R-type); otherwise those encodings are flagged illegal.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic            out_rs1_used,
  output logic            out_rs2_used,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_alu_ctrl,
  output logic [1:0]      out_result_src,
  output logic            out_reg_write,
  output logic            out_mem_write,
  output logic            out_branch,
  output logic            out_alu_src,
  output logic            out_is_jal,
  output logic            out_is_jalr,
  output logic            out_illegal
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111
  } opcode_e;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'b00000, ALU_SUB    = 5'b00001, ALU_AND    = 5'b00010,
    ALU_OR     = 5'b00011, ALU_XOR    = 5'b00100, ALU_SLL    = 5'b00101,
    ALU_SRL    = 5'b00110, ALU_SLT    = 5'b00111, ALU_SLTU   = 5'b01000,
    ALU_SRA    = 5'b01001, ALU_LUI    = 5'b01010, ALU_AUIPC  = 5'b01011,
    ALU_JAL    = 5'b01100, ALU_JALR   = 5'b01101, ALU_BEQ    = 5'b01110,
    ALU_BNE    = 5'b01111, ALU_BLT    = 5'b10000, ALU_BGE    = 5'b10001,
    ALU_MUL    = 5'b10010, ALU_MULH   = 5'b10011, ALU_MULHSU = 5'b10100,
    ALU_MULHU  = 5'b10101, ALU_DIV    = 5'b10110, ALU_DIVU   = 5'b10111,
    ALU_REM    = 5'b11000, ALU_REMU   = 5'b11001, ALU_BLTU   = 5'b11010,
    ALU_BGEU   = 5'b11011
  } alu_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            rs1_used;
    logic            rs2_used;
    logic [XLEN-1:0] imm;
    logic [4:0]      alu_ctrl;
    logic [1:0]      result_src;
    logic            reg_write;
    logic            mem_write;
    logic            branch;
    logic            alu_src;
    logic            is_jal;
    logic            is_jalr;
    logic            illegal;
  } entry_t;

  // funct3 -> ALU code shared by OP and OP-IMM (funct7 = 0000000 flavour)
  function automatic logic [4:0] base_alu(input logic [2:0] f3);
    case (f3)
      3'b000:  base_alu = ALU_ADD;
      3'b001:  base_alu = ALU_SLL;
      3'b010:  base_alu = ALU_SLT;
      3'b011:  base_alu = ALU_SLTU;
      3'b100:  base_alu = ALU_XOR;
      3'b101:  base_alu = ALU_SRL;
      3'b110:  base_alu = ALU_OR;
      default: base_alu = ALU_AND;
    endcase
  endfunction

`ifdef RV32M_DECODE_EN
  function automatic logic [4:0] mext_alu(input logic [2:0] f3);
    case (f3)
      3'b000:  mext_alu = ALU_MUL;
      3'b001:  mext_alu = ALU_MULH;
      3'b010:  mext_alu = ALU_MULHSU;
      3'b011:  mext_alu = ALU_MULHU;
      3'b100:  mext_alu = ALU_DIV;
      3'b101:  mext_alu = ALU_DIVU;
      3'b110:  mext_alu = ALU_REM;
      default: mext_alu = ALU_REMU;
    endcase
  endfunction
`endif

  opcode_e     opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        bad;
  entry_t      dec;

  assign opcode = opcode_e'(in_instr[6:0]);
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u  = {in_instr[31:12], 12'b0};
  assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                   in_instr[20], in_instr[30:21], 1'b0};

  // Combinational decode of the offered instruction into a control bundle
  always_comb begin
    dec    = '0;
    bad    = 1'b0;
    dec.pc = in_pc;
    case (opcode)
      OPC_LUI: begin
        dec.rd = in_instr[11:7]; dec.imm = imm_u; dec.alu_ctrl = ALU_LUI;
        dec.result_src = 2'b11; dec.reg_write = 1'b1; dec.alu_src = 1'b1;
      end
      OPC_AUIPC: begin
        dec.rd = in_instr[11:7]; dec.imm = imm_u; dec.alu_ctrl = ALU_AUIPC;
        dec.reg_write = 1'b1; dec.alu_src = 1'b1;
      end
      OPC_JAL: begin
        dec.rd = in_instr[11:7]; dec.imm = imm_j; dec.alu_ctrl = ALU_JAL;
        dec.result_src = 2'b10; dec.reg_write = 1'b1; dec.alu_src = 1'b1;
        dec.is_jal = 1'b1;
      end
      OPC_JALR: begin
        dec.rd = in_instr[11:7]; dec.rs1 = in_instr[19:15]; dec.rs1_used = 1'b1;
        dec.imm = imm_i; dec.alu_ctrl = ALU_JALR; dec.result_src = 2'b10;
        dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.is_jalr = 1'b1;
        bad = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        dec.rs1 = in_instr[19:15]; dec.rs2 = in_instr[24:20];
        dec.rs1_used = 1'b1; dec.rs2_used = 1'b1;
        dec.imm = imm_b; dec.branch = 1'b1;
        case (funct3)
          3'b000:  dec.alu_ctrl = ALU_BEQ;
          3'b001:  dec.alu_ctrl = ALU_BNE;
          3'b100:  dec.alu_ctrl = ALU_BLT;
          3'b101:  dec.alu_ctrl = ALU_BGE;
          3'b110:  dec.alu_ctrl = ALU_BLTU;
          3'b111:  dec.alu_ctrl = ALU_BGEU;
          default: bad = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.rd = in_instr[11:7]; dec.rs1 = in_instr[19:15]; dec.rs1_used = 1'b1;
        dec.imm = imm_i; dec.alu_ctrl = ALU_ADD; dec.result_src = 2'b01;
        dec.reg_write = 1'b1; dec.alu_src = 1'b1;
        bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        dec.rs1 = in_instr[19:15]; dec.rs2 = in_instr[24:20];
        dec.rs1_used = 1'b1; dec.rs2_used = 1'b1;
        dec.imm = imm_s; dec.alu_ctrl = ALU_ADD; dec.mem_write = 1'b1;
        dec.alu_src = 1'b1;
        bad = (funct3 > 3'b010);
      end
      OPC_OP_IMM: begin
        dec.rd = in_instr[11:7]; dec.rs1 = in_instr[19:15]; dec.rs1_used = 1'b1;
        dec.imm = imm_i; dec.reg_write = 1'b1; dec.alu_src = 1'b1;
        dec.alu_ctrl = base_alu(funct3);
        if (funct3 == 3'b001) begin
          bad = (funct7 != 7'b0000000);
        end else if (funct3 == 3'b101) begin
          if (funct7 == 7'b0100000) dec.alu_ctrl = ALU_SRA;
          else if (funct7 != 7'b0000000) bad = 1'b1;
        end
      end
      OPC_OP: begin
        dec.rd = in_instr[11:7]; dec.rs1 = in_instr[19:15]; dec.rs2 = in_instr[24:20];
        dec.rs1_used = 1'b1; dec.rs2_used = 1'b1; dec.reg_write = 1'b1;
        case (funct7)
          7'b0000000: dec.alu_ctrl = base_alu(funct3);
          7'b0100000: begin
            if (funct3 == 3'b000)      dec.alu_ctrl = ALU_SUB;
            else if (funct3 == 3'b101) dec.alu_ctrl = ALU_SRA;
            else                       bad = 1'b1;
          end
`ifdef RV32M_DECODE_EN
          7'b0000001: dec.alu_ctrl = mext_alu(funct3);
`endif
          default: bad = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase
    // Illegal encodings are neutralised to an all-zero bundle with the flag set
    if (bad) begin
      dec         = '0;
      dec.pc      = in_pc;
      dec.illegal = 1'b1;
    end
  end

  entry_t         mem [DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic           push, pop;
  entry_t         head;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    next_ptr = (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // Entry storage; contents are only observed while count says they are valid
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dec;
  end

  // FIFO pointers and occupancy; flush empties the buffer at the edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Present the head entry, forcing every field to zero while empty
  always_comb begin
    head = '0;
    if (out_valid) head = mem[rd_ptr];
  end

  assign out_pc         = head.pc;
  assign out_rd         = head.rd;
  assign out_rs1        = head.rs1;
  assign out_rs2        = head.rs2;
  assign out_rs1_used   = head.rs1_used;
  assign out_rs2_used   = head.rs2_used;
  assign out_imm        = head.imm;
  assign out_alu_ctrl   = head.alu_ctrl;
  assign out_result_src = head.result_src;
  assign out_reg_write  = head.reg_write;
  assign out_mem_write  = head.mem_write;
  assign out_branch     = head.branch;
  assign out_alu_src    = head.alu_src;
  assign out_is_jal     = head.is_jal;
  assign out_is_jalr    = head.is_jalr;
  assign out_illegal    = head.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: queue-based reference model with a per-cycle
// compare process, directed literal checks, then randomized traffic.
module tb_decode_stage;
  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0;
  logic flush = 1'b0;
  logic out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [XLEN-1:0] in_pc = '0;
  logic in_ready, out_valid;
  logic [XLEN-1:0] out_pc, out_imm;
  logic [4:0] out_rd, out_rs1, out_rs2, out_alu_ctrl;
  logic out_rs1_used, out_rs2_used;
  logic [1:0] out_result_src;
  logic out_reg_write, out_mem_write, out_branch, out_alu_src;
  logic out_is_jal, out_is_jalr, out_illegal;

  decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_rd(out_rd), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_rs1_used(out_rs1_used), .out_rs2_used(out_rs2_used),
    .out_imm(out_imm), .out_alu_ctrl(out_alu_ctrl), .out_result_src(out_result_src),
    .out_reg_write(out_reg_write), .out_mem_write(out_mem_write),
    .out_branch(out_branch), .out_alu_src(out_alu_src), .out_is_jal(out_is_jal),
    .out_is_jalr(out_is_jalr), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd, rs1, rs2;
    logic        u1, u2;
    logic [31:0] imm;
    logic [4:0]  alu;
    logic [1:0]  res;
    logic        rw, mw, br, src, jal, jalr, ill;
  } bundle_t;

  int checks = 0;
  int failures = 0;
  bit run_cmp = 1'b0;
  bundle_t q[$];

  // R/I funct3 -> code: add sll slt sltu xor srl or and (index 0 in low bits)
  localparam logic [39:0] RTAB = {5'd2, 5'd3, 5'd6, 5'd4, 5'd8, 5'd7, 5'd5, 5'd0};
  // branch funct3 -> code (entries 2,3 unused)
  localparam logic [39:0] BTAB = {5'd27, 5'd26, 5'd17, 5'd16, 5'd0, 5'd0, 5'd15, 5'd14};

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic bundle_t act_bundle();
    bundle_t a;
    a = '{pc: out_pc, rd: out_rd, rs1: out_rs1, rs2: out_rs2, u1: out_rs1_used,
          u2: out_rs2_used, imm: out_imm, alu: out_alu_ctrl, res: out_result_src,
          rw: out_reg_write, mw: out_mem_write, br: out_branch, src: out_alu_src,
          jal: out_is_jal, jalr: out_is_jalr, ill: out_illegal};
    return a;
  endfunction

  // Reference decode computed from the instruction-set rules
  function automatic bundle_t model_dec(input logic [31:0] i, input logic [31:0] pc);
    bundle_t b;
    logic [39:0] rt, bt;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [4:0] rd, r1, r2;
    logic [31:0] ii, is, ib, iu, ij;
    bit ok;
    rt = RTAB; bt = BTAB;
    op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
    rd = i[11:7]; r1 = i[19:15]; r2 = i[24:20];
    ii = 32'($signed(i[31:20]));
    is = 32'($signed({i[31:25], i[11:7]}));
    ib = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
    iu = i & 32'hFFFF_F000;
    ij = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
    b = '0; ok = 1;
    case (op)
      7'h37: begin b.rd = rd; b.imm = iu; b.alu = 10; b.res = 3; b.rw = 1; b.src = 1; end
      7'h17: begin b.rd = rd; b.imm = iu; b.alu = 11; b.rw = 1; b.src = 1; end
      7'h6F: begin b.rd = rd; b.imm = ij; b.alu = 12; b.res = 2; b.rw = 1; b.src = 1; b.jal = 1; end
      7'h67: begin
        ok = (f3 == 0);
        b.rd = rd; b.rs1 = r1; b.u1 = 1; b.imm = ii; b.alu = 13; b.res = 2;
        b.rw = 1; b.src = 1; b.jalr = 1;
      end
      7'h63: begin
        ok = (f3 != 2) && (f3 != 3);
        b.rs1 = r1; b.rs2 = r2; b.u1 = 1; b.u2 = 1; b.imm = ib; b.br = 1;
        b.alu = bt[f3*5 +: 5];
      end
      7'h03: begin
        ok = (f3 <= 2) || (f3 == 4) || (f3 == 5);
        b.rd = rd; b.rs1 = r1; b.u1 = 1; b.imm = ii; b.res = 1; b.rw = 1; b.src = 1;
      end
      7'h23: begin
        ok = (f3 <= 2);
        b.rs1 = r1; b.rs2 = r2; b.u1 = 1; b.u2 = 1; b.imm = is; b.mw = 1; b.src = 1;
      end
      7'h13: begin
        b.rd = rd; b.rs1 = r1; b.u1 = 1; b.imm = ii; b.rw = 1; b.src = 1;
        b.alu = rt[f3*5 +: 5];
        if (f3 == 1) ok = (f7 == 0);
        if (f3 == 5) begin
          ok = (f7 == 0) || (f7 == 7'h20);
          if (f7 == 7'h20) b.alu = 9;
        end
      end
      7'h33: begin
        b.rd = rd; b.rs1 = r1; b.rs2 = r2; b.u1 = 1; b.u2 = 1; b.rw = 1;
        if (f7 == 0) b.alu = rt[f3*5 +: 5];
        else if (f7 == 7'h20 && f3 == 0) b.alu = 1;
        else if (f7 == 7'h20 && f3 == 5) b.alu = 9;
`ifdef RV32M_DECODE_EN
        else if (f7 == 1) b.alu = 5'(18 + int'(f3));
`endif
        else ok = 0;
      end
      default: ok = 0;
    endcase
    if (!ok) begin b = '0; b.ill = 1; end
    b.pc = pc;
    return b;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] op, f7;
    case ($urandom_range(0, 9))
      0: op = 7'h37; 1: op = 7'h17; 2: op = 7'h6F; 3: op = 7'h67; 4: op = 7'h63;
      5: op = 7'h03; 6: op = 7'h23; 7: op = 7'h13; 8: op = 7'h33;
      default: op = 7'($urandom);
    endcase
    case ($urandom_range(0, 3))
      0: f7 = 7'h00; 1: f7 = 7'h20; 2: f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
    return {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), op};
  endfunction

  // Model FIFO update at each active edge; reset clears it asynchronously
  always @(posedge clk or negedge reset_n) begin
    bit do_push, do_pop;
    if (!reset_n) q.delete();
    else begin
      do_push = in_valid && (q.size() < DEPTH) && !flush;
      do_pop  = (q.size() > 0) && out_ready && !flush;
      if (flush) q.delete();
      else begin
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(model_dec(in_instr, in_pc));
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    bundle_t e;
    if (run_cmp) begin
      e = (q.size() != 0) ? q[0] : '0;
      chk("cyc_valid", out_valid, q.size() != 0);
      chk("cyc_ready", in_ready, q.size() < DEPTH);
      chk("cyc_bundle", act_bundle(), e);
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_bundle", act_bundle(), 0);
    reset_n = 1; run_cmp = 1; out_ready = 1;

    // addi x1,x0,5
    in_valid = 1; in_instr = 32'h00500093; in_pc = 32'h100;
    @(negedge clk);
    chk("addi_valid", out_valid, 1); chk("addi_rd", out_rd, 1);
    chk("addi_rs1", out_rs1, 0); chk("addi_rs1_used", out_rs1_used, 1);
    chk("addi_rs2_used", out_rs2_used, 0); chk("addi_imm", out_imm, 5);
    chk("addi_alu", out_alu_ctrl, 0); chk("addi_src", out_alu_src, 1);
    chk("addi_rw", out_reg_write, 1);

    // mul x3,x1,x2
    in_instr = 32'h022081B3; in_pc = 32'h104;
    @(negedge clk);
    chk("mul_pc", out_pc, 32'h104);
`ifdef RV32M_DECODE_EN
    chk("mul_alu", out_alu_ctrl, 5'b10010); chk("mul_rd", out_rd, 3);
    chk("mul_ill", out_illegal, 0);
`else
    chk("mul_ill", out_illegal, 1); chk("mul_rw", out_reg_write, 0);
    chk("mul_rd", out_rd, 0);
`endif

    // bltu x1,x2,+8
    in_instr = 32'h0020E463; in_pc = 32'h108;
    @(negedge clk);
    in_valid = 0;
    chk("bltu_imm", out_imm, 8); chk("bltu_alu", out_alu_ctrl, 5'b11010);
    chk("bltu_br", out_branch, 1); chk("bltu_rw", out_reg_write, 0);
    chk("bltu_rd", out_rd, 0);
    @(negedge clk);
    chk("drain_empty", out_valid, 0);

    // fill with out_ready low
    out_ready = 0; in_valid = 1; in_instr = 32'h00100113; in_pc = 32'h200;
    @(negedge clk);
    chk("fill1_ready", in_ready, 1);
    in_pc = 32'h204;
    @(negedge clk);
    chk("fill2_ready", in_ready, 0);
    in_pc = 32'h208;
    @(negedge clk);
    chk("fill3_ready", in_ready, 0); chk("fill3_head", out_pc, 32'h200);
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    chk("drain1_head", out_pc, 32'h204); chk("drain1_valid", out_valid, 1);
    @(negedge clk);
    chk("drain2_valid", out_valid, 0); chk("drain2_ready", in_ready, 1);

    // flush with two entries buffered
    out_ready = 0; in_valid = 1; in_pc = 32'h300;
    @(negedge clk);
    in_pc = 32'h304;
    @(negedge clk);
    chk("preflush_ready", in_ready, 0);
    flush = 1; in_pc = 32'h308;
    @(negedge clk);
    flush = 0; in_valid = 0;
    chk("flush_valid", out_valid, 0); chk("flush_ready", in_ready, 1);

    // flush with room to accept: offered instruction must be discarded
    in_valid = 1; in_pc = 32'h310;
    @(negedge clk);
    flush = 1; in_pc = 32'h314; out_ready = 1;
    @(negedge clk);
    flush = 0; in_valid = 0;
    chk("flush2_valid", out_valid, 0);
    @(negedge clk);
    chk("flush2_valid_b", out_valid, 0);

    // illegal opcode, then asynchronous reset mid-stream
    out_ready = 0; in_valid = 1; in_instr = 32'h0000007F; in_pc = 32'h400;
    @(negedge clk);
    in_instr = 32'h00500093; in_pc = 32'h404;
    chk("ill_flag", out_illegal, 1); chk("ill_rw", out_reg_write, 0);
    chk("ill_alu", out_alu_ctrl, 0); chk("ill_valid", out_valid, 1);
    @(negedge clk);
    in_valid = 0;
    #2 reset_n = 0;
    #1;
    chk("arst_valid", out_valid, 0); chk("arst_ready", in_ready, 1);
    chk("arst_bundle", act_bundle(), 0);
    @(negedge clk);
    reset_n = 1;

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 29) == 0);
      in_instr  = rand_instr();
      in_pc     = {$urandom} & 32'hFFFF_FFFC;
      @(negedge clk);
    end
    in_valid = 0; flush = 0;
    @(negedge clk);
    run_cmp = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
